// File: rtl/mac_tile_ctrl_if.sv
// Operand, MAC-array and result buses of the MAC tile controller.
// Handshake rule for op_* and res_*: a beat transfers on a rising clk edge
// where valid && ready are both 1; once raised, valid and its payload hold
// until that edge, and ready never depends combinationally on valid.
interface mac_tile_ctrl_if #(
  parameter int MAX_MACS          = 64,
  parameter int DATA_WIDTH        = 8,
  parameter int MAX_GROUPS        = 8,
  parameter int MAC_BIT_PER_GROUP = 7
);
  localparam int BUS_W = MAX_MACS * DATA_WIDTH;

  logic                                    op_valid;
  logic                                    op_ready;
  logic [BUS_W-1:0]                        op_data;
  logic [BUS_W-1:0]                        op_weight;

  logic                                    mac_valid_in;
  logic [BUS_W-1:0]                        mac_data;
  logic [BUS_W-1:0]                        mac_weight;
  logic [3:0]                              mac_num_groups;
  logic [MAX_GROUPS*MAC_BIT_PER_GROUP-1:0] mac_num_macs;

  logic                                    mac_valid_out;
  logic [MAX_GROUPS*32-1:0]                mac_out;

  logic                                    res_valid;
  logic                                    res_ready;
  logic signed [31:0]                      res_data;

  // Controller side
  modport master (
    input  op_valid, op_data, op_weight, mac_valid_out, mac_out, res_ready,
    output op_ready, mac_valid_in, mac_data, mac_weight, mac_num_groups,
           mac_num_macs, res_valid, res_data
  );

  // Environment side (operand source, MAC array, result sink)
  modport slave (
    output op_valid, op_data, op_weight, mac_valid_out, mac_out, res_ready,
    input  op_ready, mac_valid_in, mac_data, mac_weight, mac_num_groups,
           mac_num_macs, res_valid, res_data
  );
endinterface

// File: rtl/mac_tile_ctrl.sv
// MAC tile controller: splits a dot-product of vec_len elements into tiles of
// MAX_MACS lanes, issues one tile per operand beat to the MAC array, sums the
// per-tile results and hands the final sum out on the result handshake.
module mac_tile_ctrl #(
  parameter int MAX_MACS          = 64,
  parameter int DATA_WIDTH        = 8,
  parameter int MAX_GROUPS        = 8,
  parameter int MAC_BIT_PER_GROUP = 7,
  parameter int LEN_WIDTH         = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] vec_len,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           state_dbg,
  mac_tile_ctrl_if.master      bus
);
  localparam int BUS_W  = MAX_MACS * DATA_WIDTH;
  localparam int CNT_W  = 11;
  localparam int LANE_W = MAC_BIT_PER_GROUP;
  localparam int NM_W   = MAX_GROUPS * MAC_BIT_PER_GROUP;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    RESULT = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q;
  logic [CNT_W-1:0]     tiles_q, issued_q, returned_q;
  logic [31:0]          acc_q;
  logic                 done_q;

  logic                 mac_valid_q;
  logic [BUS_W-1:0]     mac_data_q, mac_weight_q;
  logic [3:0]           mac_groups_q;
  logic [NM_W-1:0]      mac_macs_q;

  logic [CNT_W-1:0]     tiles_in;
  logic [LEN_WIDTH-1:0] last_lanes;
  logic [LANE_W-1:0]    lane_cnt;
  logic [BUS_W-1:0]     data_m, weight_m;
  logic [NM_W-1:0]      macs_d;
  logic                 op_ready_w, fire, ret;
  logic [CNT_W-1:0]     returned_next;
  logic                 unused_mac_out;

  // Only group 0 is ever used, so the other result groups are don't-care.
  assign unused_mac_out = ^bus.mac_out[MAX_GROUPS*32-1:32];

  assign tiles_in = CNT_W'((32'(vec_len) + 32'(MAX_MACS - 1)) / 32'(MAX_MACS));
  // Lanes in the final tile: whatever is left after the full tiles.
  assign last_lanes = len_q - LEN_WIDTH'((32'(tiles_q) - 32'd1) * 32'(MAX_MACS));
  assign lane_cnt   = (issued_q == tiles_q - CNT_W'(1)) ? LANE_W'(last_lanes)
                                                        : LANE_W'(MAX_MACS);

  assign op_ready_w    = (state_q == ISSUE) && (issued_q < tiles_q);
  assign fire          = bus.op_valid && op_ready_w;
  // Returns only count while a job is in flight; late ones are dropped.
  assign ret           = bus.mac_valid_out && (state_q == ISSUE || state_q == DRAIN);
  assign returned_next = returned_q + CNT_W'(ret);

  // Zero lanes beyond this tile's lane count; group 0 carries the count.
  always_comb begin
    data_m   = '0;
    weight_m = '0;
    macs_d   = '0;
    macs_d[LANE_W-1:0] = lane_cnt;
    for (int i = 0; i < MAX_MACS; i++) begin
      if ($unsigned(i) < 32'(lane_cnt)) begin
        data_m[i*DATA_WIDTH +: DATA_WIDTH]   = bus.op_data[i*DATA_WIDTH +: DATA_WIDTH];
        weight_m[i*DATA_WIDTH +: DATA_WIDTH] = bus.op_weight[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (vec_len == '0) ? RESULT : ISSUE;
      ISSUE:   if (fire && (issued_q + CNT_W'(1) == tiles_q)) state_d = DRAIN;
      DRAIN:   if (returned_next == tiles_q) state_d = RESULT;
      RESULT:  if (bus.res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Job bookkeeping: length, tile counters, accumulator and done pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q      <= '0;
      tiles_q    <= '0;
      issued_q   <= '0;
      returned_q <= '0;
      acc_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= (state_q == RESULT) && bus.res_ready;
      if (state_q == IDLE && start) begin
        len_q      <= vec_len;
        tiles_q    <= tiles_in;
        issued_q   <= '0;
        returned_q <= '0;
        acc_q      <= '0;
      end else if (state_q == RESULT && bus.res_ready) begin
        len_q      <= '0;
        tiles_q    <= '0;
        issued_q   <= '0;
        returned_q <= '0;
        acc_q      <= '0;
      end else begin
        if (fire) issued_q <= issued_q + CNT_W'(1);
        if (ret) begin
          returned_q <= returned_next;
          // Group 0 is already 32 bits, so sign extension is the identity.
          acc_q      <= acc_q + bus.mac_out[31:0];
        end
      end
    end
  end

  // MAC array drive: one registered beat per accepted operand tile
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mac_valid_q  <= 1'b0;
      mac_data_q   <= '0;
      mac_weight_q <= '0;
      mac_groups_q <= '0;
      mac_macs_q   <= '0;
    end else begin
      mac_valid_q <= fire;
      if (fire) begin
        mac_data_q   <= data_m;
        mac_weight_q <= weight_m;
        mac_groups_q <= 4'd1;
        mac_macs_q   <= macs_d;
      end
    end
  end

  assign busy               = (state_q != IDLE);
  assign done               = done_q;
  assign state_dbg          = state_q;
  assign bus.op_ready       = op_ready_w;
  assign bus.mac_valid_in   = mac_valid_q;
  assign bus.mac_data       = mac_data_q;
  assign bus.mac_weight     = mac_weight_q;
  assign bus.mac_num_groups = mac_groups_q;
  assign bus.mac_num_macs   = mac_macs_q;
  assign bus.res_valid      = (state_q == RESULT);
  assign bus.res_data       = (state_q == RESULT) ? acc_q : '0;
endmodule

// File: doc/mac_tile_ctrl.md
MAC_TILE_CTRL -- requirements
Module: mac_tile_ctrl

Interface
REQ-001 SHALL have parameter MAX_MACS, default 64, meaning lanes per MAC pass.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning signed operand width.
REQ-003 SHALL have parameter MAX_GROUPS, default 8, meaning MAC group slots.
REQ-004 SHALL have parameter MAC_BIT_PER_GROUP, default 7, meaning per-group MAC-count field width.
REQ-005 SHALL have parameter LEN_WIDTH, default 16, meaning vector-length field width.
REQ-006 SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-007 SHALL have port rst, input, 1 bit, asynchronous active-low reset.
REQ-008 SHALL have ports start (input, 1), vec_len (input, LEN_WIDTH), busy (output, 1) and done (output, 1, one-cycle pulse).
REQ-009 SHALL have ports op_valid (input, 1), op_ready (output, 1), op_data (input, MAX_MACS*DATA_WIDTH) and op_weight (input, MAX_MACS*DATA_WIDTH); this is the operand stream, one tile per beat.
REQ-010 SHALL have ports mac_valid_in (output, 1), mac_data (output, MAX_MACS*DATA_WIDTH), mac_weight (output, MAX_MACS*DATA_WIDTH), mac_num_groups (output, 4) and mac_num_macs (output, MAX_GROUPS*MAC_BIT_PER_GROUP); these drive the MAC array.
REQ-011 SHALL have ports mac_valid_out (input, 1) and mac_out (input, MAX_GROUPS*32); these carry MAC array results.
REQ-012 SHALL have ports res_valid (output, 1), res_ready (input, 1) and res_data (output, 32, signed).

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, DRAIN and RESULT.
REQ-014 In IDLE, start=1 SHALL latch vec_len and compute tiles = ceil(vec_len/MAX_MACS); the next state is ISSUE, or RESULT with accumulator 0 if vec_len=0.
REQ-015 start SHALL be ignored in any state other than IDLE.
REQ-016 busy SHALL be 1 in every state other than IDLE.
REQ-017 op_ready SHALL equal (state==ISSUE && issued<tiles), driven combinationally from registered state.
REQ-018 Each op_valid&&op_ready beat SHALL register the operands and assert mac_valid_in exactly one cycle later for one cycle.
REQ-019 Gaps in op_valid SHALL produce cycles with mac_valid_in=0; no beat is dropped or duplicated.
REQ-020 Lane count per tile SHALL be MAX_MACS, except the final tile, which uses vec_len - (tiles-1)*MAX_MACS.
REQ-021 mac_data and mac_weight lanes at or above the lane count SHALL be forced to zero.
REQ-022 mac_num_groups SHALL be 1 while issuing.
REQ-023 The group-0 field of mac_num_macs SHALL equal the lane count; all other group fields SHALL be 0.
REQ-024 mac_num_groups and mac_num_macs SHALL be valid in the same cycle as mac_valid_in.
REQ-025 After the last tile is issued, the FSM SHALL move ISSUE->DRAIN.
REQ-026 On each mac_valid_out while busy, the block SHALL add sign-extended mac_out[31:0] to a 32-bit accumulator with two's-complement wrap, and increment a returned counter.
REQ-027 Completion SHALL be detected by counting returned results, not by fixed latency; when returned==tiles, the FSM SHALL enter RESULT.
REQ-028 A return arriving in the same cycle as the last issue SHALL be counted.
REQ-029 mac_valid_out in IDLE or RESULT SHALL be ignored.
REQ-030 In RESULT, res_valid SHALL be 1 and res_data SHALL be the accumulator, both held stable until res_ready.
REQ-031 On the res_valid&&res_ready handshake, done SHALL pulse for 1 cycle, the accumulator and counters SHALL clear, and the FSM SHALL return to IDLE; a new start is accepted the following cycle.
REQ-032 Maximum vec_len SHALL give tiles=ceil(65535/64)=1024; the tile counters SHALL be 11 bits and SHALL NOT wrap.

Reset
REQ-033 While rst=0, asynchronously: state=IDLE; busy, done, op_ready, mac_valid_in and res_valid =0; mac_data, mac_weight, mac_num_groups, mac_num_macs and res_data =0; accumulator and counters =0.
REQ-034 Reset mid-job SHALL abandon the job with no result.
REQ-035 Late mac_valid_out arriving after reset release SHALL be ignored per REQ-029.

Verification
REQ-036 vec_len=64, all data=1, weight=2, op_valid held high -> exactly one mac_valid_in with mac_num_macs group0=64, res_data=128, done after the res handshake.
REQ-037 vec_len=100, data=3, weight=-1, lanes 36..63 of beat 2 =0x7F -> two issues with group0 counts 64 then 36, masked lanes driven 0, res_data=-300.
REQ-038 vec_len=0 -> no mac_valid_in, res_valid=1 with res_data=0 one cycle after start.
REQ-039 res_ready held low 5 cycles in RESULT, with start pulsed -> res_valid and res_data stable, start ignored, single done after res_ready.
REQ-040 vec_len=256 with op_valid toggling every other cycle -> 4 issues, no extra or missing beats, correct sum.
REQ-041 rst low during ISSUE of a 4-tile job, stale mac_valid_out after release -> all outputs 0, IDLE, no res_valid; next job correct.
